// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the fetch control slice
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    RUN   = 3'd1,
    HOLD  = 3'd2,
    FLUSH = 3'd3,
    HALT  = 3'd4
  } fetch_state_e;
endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: drives fetch-stage control through boot, run, hold, flush and halt
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dec_ready,
  input  logic            load_use_hazard,
  input  logic            ex_branch_valid,
  input  logic [XLEN-1:0] ex_branch_target,
  input  logic            halt_req,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            fetch_r_in,
  output logic            fetch_stall,
  output logic            fetch_redirect,
  output logic [XLEN-1:0] fetch_target,
  output logic [XLEN-1:0] fetch_pc_prev,
  output logic            flush_dec,
  output logic            halted,
  output logic [15:0]     redirect_count
);
  fetch_state_e state, state_nxt;
  logic [2:0] cnt;
  logic hold_req, run_like, take_halt, take_br;
  always_comb begin
    hold_req = load_use_hazard | ~dec_ready;
    run_like = (state == RUN) | (state == HOLD);
    // a halt request only comes from a live decode slot, so flush cycles ignore it
    take_halt = ~rst & run_like & halt_req;
    take_br = ~rst & ex_branch_valid & ~take_halt & (run_like | (state == FLUSH));
    fetch_r_in = rst ? 1'b0 :
                 ((state == BOOT) | (state == FLUSH)) ? 1'b1 :
                 run_like ? (take_br | ~hold_req) : 1'b0;
    fetch_stall = rst | (state == BOOT) | (state == FLUSH) | (state == HALT) | take_br;
    fetch_redirect = ~rst & ((state == BOOT) | take_br);
    fetch_target = (rst | (state == BOOT)) ? RESET_PC : ex_branch_target;
    fetch_pc_prev = fetch_pc;
    flush_dec = rst | (state == BOOT) | (state == FLUSH) | take_br;
    halted = ~rst & (state == HALT);
    state_nxt = take_halt ? HALT :
                take_br ? FLUSH :
                (state == BOOT) ? RUN :
                run_like ? (hold_req ? HOLD : RUN) :
                (state == FLUSH) ? ((cnt == 3'd0) ? RUN : FLUSH) :
                (state == HALT) ? HALT : BOOT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      cnt <= 3'd0;
      redirect_count <= 16'd0;
    end else begin
      state <= state_nxt;
      cnt <= take_br ? 3'(FLUSH_CYCLES - 1) :
             ((state == FLUSH) && (cnt != 3'd0)) ? cnt - 3'd1 : cnt;
      redirect_count <= redirect_count + 16'(take_br);
    end
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control block for the instruction-fetch stage. It generates the fetch stage's update enable, stall, redirect select and previous-PC inputs, so fetch follows a boot, run, hold, flush and halt sequence. It sits between the fetch stage, decode (hazard and ready signals) and execute (taken-branch report). It is the single owner of the fetch-stage control inputs.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetched instruction after reset
- FLUSH_CYCLES, 2, bubble cycles after a redirect (legal range 1..7)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous and active-high
- dec_ready  in  1  decode can accept an instruction this cycle
- load_use_hazard  in  1  decode requests a one-cycle hold
- ex_branch_valid  in  1  execute reports a taken branch or jump; valid only when its instruction is valid
- ex_branch_target  in  32  redirect address from execute
- halt_req  in  1  decode saw ECALL or EBREAK
- fetch_pc  in  32  current fetch PC_out, fed back
- fetch_r_in  out  1  fetch register update enable
- fetch_stall  out  1  forces fetch v_out low on the next edge
- fetch_redirect  out  1  drives both fetch COMP_alu and v_in; selects fetch_target
- fetch_target  out  32  drives fetch PC_alu
- fetch_pc_prev  out  32  drives fetch PC_prev
- flush_dec  out  1  kills the instruction currently in decode
- halted  out  1  core halted
- redirect_count  out  16  number of accepted redirects

## Operation

- States:
  - BOOT (reset state)
  - RUN
  - HOLD
  - FLUSH
  - HALT
- A 3-bit flush counter runs alongside the state register.
- Event priority per cycle: rst > halt_req > ex_branch_valid > (load_use_hazard | !dec_ready) > normal.
- BOOT (one cycle):
  - Outputs: fetch_redirect=1, fetch_target=RESET_PC, fetch_r_in=1, fetch_stall=1, flush_dec=1.
  - Next state: RUN.
- RUN:
  - Outputs: fetch_r_in=1, fetch_stall=0, fetch_redirect=0, flush_dec=0.
- Transitions out of RUN:
  - ex_branch_valid: in the same cycle drive fetch_redirect=1, fetch_target=ex_branch_target, flush_dec=1 and fetch_stall=1. Load the flush counter with FLUSH_CYCLES-1, increment redirect_count, go to FLUSH.
  - halt_req: go to HALT.
  - load_use_hazard or !dec_ready: go to HOLD.
- HOLD:
  - Outputs: fetch_r_in=0, fetch_stall=0, so fetch holds its PC and IR.
  - Return to RUN on the first cycle in which the hold condition is deasserted. RUN outputs apply in that cycle.
  - ex_branch_valid in HOLD is handled exactly as in RUN.
- FLUSH:
  - Outputs: fetch_r_in=1, fetch_stall=1, flush_dec=1.
  - Decrement the counter; at 0, go to RUN.
  - A new ex_branch_valid in FLUSH restarts the redirect: counter reloaded, redirect_count incremented.
- HALT:
  - Outputs: fetch_r_in=0, fetch_stall=1, halted=1.
  - All inputs except rst are ignored; exit only via rst.
- fetch_target equals ex_branch_target in every state except BOOT.
- fetch_pc_prev equals fetch_pc in every state, so sequential fetch computes fetch_pc+4.
- redirect_count is 16-bit and wraps from 16'hFFFF to 0. BOOT does not count.

## Timing

- All outputs are combinational from the state register, the flush counter and the inputs. State, counter and redirect_count update on the rising edge of clk.
- Values while rst is high:
  - fetch_r_in=0, fetch_stall=1, fetch_redirect=0, flush_dec=1, halted=0
  - fetch_target=RESET_PC, fetch_pc_prev=fetch_pc
  - On the edge: state←BOOT, redirect_count←0.
- Reset asserted mid-FLUSH or in HALT returns to BOOT on the next edge. Any pending redirect is discarded.
- Boot latency: rst falls at edge E. BOOT runs in the cycle after E, so fetch PC_out=RESET_PC after edge E+1. The first valid instruction (v_out=1) appears after edge E+2.
- Redirect latency: ex_branch_valid in cycle N:
  - PC_out=target after edge N+1.
  - v_out is low for FLUSH_CYCLES+1 cycles, then high.
- Hold: one cycle of load_use_hazard freezes PC_out and IR_out for exactly one edge.
- Simultaneous halt_req and ex_branch_valid: halt wins and redirect_count is unchanged.

## Structure

- Shared package fetch_pkg:
  - State enum: BOOT=3'd0, RUN=3'd1, HOLD=3'd2, FLUSH=3'd3, HALT=3'd4
  - XLEN=32
  - Default RESET_PC constant
- No sub-module required. The flush counter and redirect_count stay inline.
- The top level instantiates fetch_sequencer next to fetch and wires fetch_redirect to both COMP_alu and v_in.

## Test plan

- Reset release with RESET_PC=32'h100 → BOOT for one cycle, fetch PC_out=32'h100, then 32'h104, 32'h108. v_out is first high after the second edge following reset release.
- Taken branch to 32'h40 in RUN (FLUSH_CYCLES=2) → PC_out=32'h40 next edge, flush_dec high for 3 cycles, v_out low for 3 cycles, redirect_count=1.
- load_use_hazard pulsed for 1 cycle, then dec_ready low for 3 cycles → PC_out held 1 cycle then 3 cycles; no skipped or duplicated PC.
- Second branch (to 32'h80) during FLUSH after a first to 32'h40 → PC_out=32'h80, counter reloaded, redirect_count=2.
- halt_req and ex_branch_valid in the same cycle → HALT, halted=1, fetch_r_in=0, redirect_count unchanged; rst then gives BOOT with PC_out=RESET_PC.
- 65536 redirects → redirect_count wraps to 0. rst asserted mid-FLUSH → BOOT next cycle with count 0.
